compressor_sum_accumulator: RTL and testbench
=============================================

Name: compressor_sum_accumulator

Overview:
Downstream stage of the 6:3 compressor. It takes the three compressed vectors X, Y and Z and reconstructs the full six-operand sum as X + 2Y + 4Z. It then accumulates ACC_LEN consecutive sums, for example the row sums of a spatial-filter kernel, and emits one result per window. The compressor issues X one cycle after Y and Z; this block absorbs that skew internally.

Parameters:
- WIDTH, 45, width of the X/Y/Z inputs; must match the compressor.
- OUT_WIDTH, 48, accumulator and output width; legal only if OUT_WIDTH >= WIDTH+3.
- ACC_LEN, 3, number of reconstructed sums per output; legal range 1..255. Counter width is clog2(ACC_LEN), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- yz_valid  input  1  marks Y and Z valid this cycle; the matching X arrives on the next cycle.
- X  input  WIDTH  weight-1 vector, one cycle later than its Y/Z.
- Y  input  WIDTH  weight-2 vector.
- Z  input  WIDTH  weight-4 vector.
- clear  input  1  synchronous flush of the pipeline and the window.
- sum_out  output  OUT_WIDTH  accumulated window sum.
- sum_valid  output  1  one-cycle pulse when sum_out is updated.
- overflow  output  1  sticky flag: the accumulator exceeded 2^OUT_WIDTH-1.

Behaviour:
- Reset is asynchronous on rst_n low. Reset values: sum_out=0, sum_valid=0, overflow=0. All internal state is also zeroed: p1, s2, acc, cnt, v1, v2.
- Stage 1, cycle n: p1 <= (Z<<2) + (Y<<1), zero-extended to OUT_WIDTH; v1 <= yz_valid.
- Stage 2, cycle n+1: s2 <= p1 + X, with X as sampled in cycle n+1; v2 <= v1. s2 cannot overflow, since its maximum is 7*(2^WIDTH-1).
- Stage 3, cycle n+2, taken only when v2=1:
  - candidate = (cnt==0 ? 0 : acc) + s2, computed at OUT_WIDTH+1 bits.
  - If cnt == ACC_LEN-1: sum_out <= candidate[OUT_WIDTH-1:0]; sum_valid <= 1; cnt <= 0.
  - Otherwise: acc <= candidate[OUT_WIDTH-1:0]; cnt <= cnt+1.
  - If candidate[OUT_WIDTH]=1: overflow <= 1. The default overflow behaviour is wrap mod 2^OUT_WIDTH.
- sum_valid is 0 in every cycle that does not complete a window.
- sum_out holds its value between pulses.
- Latency: the first yz_valid of a window at cycle n gives sum_valid high in cycle n+3 when ACC_LEN=1. In general, the last sample's yz_valid at cycle m gives sum_valid high in cycle m+3.
- Throughput: one sample per cycle. yz_valid may be high on consecutive cycles with no bubbles. Gaps in yz_valid pause the window and do not reset it.
- clear=1 forces cnt<=0, acc<=0, v1<=0, v2<=0, sum_valid<=0 and overflow<=0. sum_out is held.
- clear takes priority over a simultaneous v2 or window completion: that sample is discarded and no pulse is generated.
- X is ignored in any cycle where v1=0.
- Reset asserted mid-window abandons the partial sum; the first valid sample after release starts a new window.
- ACC_LEN=1: every valid sample produces a pulse, and acc is unused.

Optional Feature:
COMP_SUM_SAT_EN
- Defined: when candidate[OUT_WIDTH]=1, the stored value (acc or sum_out) is forced to 2^OUT_WIDTH-1. It remains saturated through the rest of the window. overflow is still set.
- Undefined: wrap-around as described in Behaviour.

Test Plan:
All scenarios use WIDTH=8 and OUT_WIDTH=12 unless stated.
1. Basic sum, ACC_LEN=1: Y=1, Z=1, yz_valid=1 at cycle 0; X=3 at cycle 1 -> sum_out=9 with sum_valid high in cycle 3 only.
2. Window, ACC_LEN=3: three back-to-back samples (Y=1, Z=1, X=3) -> one pulse with sum_out=27 at cycle 5. No pulse at cycles 3 or 4.
3. Gapped window, ACC_LEN=3: same three samples with yz_valid low for 2 cycles between them -> a single pulse with sum_out=27. X on gap cycles is set to 0xFF and must be ignored.
4. Overflow, ACC_LEN=2: X=Y=Z=0xFF for two samples (1785 each, total 3570 < 4096) -> sum_out=3570, overflow=0. Third and fourth samples with OUT_WIDTH=11 -> wrap to 3570-2048=1522 and overflow=1. Under COMP_SUM_SAT_EN -> sum_out=2047.
5. Clear mid-window, ACC_LEN=3: two samples of 9, then clear aligned with the third sample's v2 -> no pulse and overflow=0. The next three samples of 9 -> sum_out=27.
6. Reset mid-window: rst_n low asynchronously between cycles -> sum_out=0 and sum_valid=0 immediately. After release, a fresh ACC_LEN=3 window of 9s -> 27.

Source files
------------

// File: rtl/compressor_sum_accumulator.sv
// Rebuilds X + 2Y + 4Z from the 6:3 compressor outputs and accumulates ACC_LEN sums per window.
// Latency: a window's last Y/Z at cycle m gives a one-cycle sum_valid pulse in cycle m+3.
// No backpressure: one sample per cycle is always accepted. COMP_SUM_SAT_EN: saturate instead of wrap.
module compressor_sum_accumulator #(
    parameter int WIDTH     = 45,
    parameter int OUT_WIDTH = 48,   // must be >= WIDTH+3 so X + 2Y + 4Z always fits
    parameter int ACC_LEN   = 3     // 1..255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 yz_valid,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    input  logic [WIDTH-1:0]     Z,
    input  logic                 clear,
    output logic [OUT_WIDTH-1:0] sum_out,
    output logic                 sum_valid,
    output logic                 overflow
);

    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ACC_LEN - 1);

    logic [OUT_WIDTH-1:0] p1;
    logic [OUT_WIDTH-1:0] s2;
    logic [OUT_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 v1;
    logic                 v2;
    logic [OUT_WIDTH:0]   candidate;
    logic [OUT_WIDTH-1:0] stored;

    // The window restarts from zero whenever cnt is 0, so acc never needs an explicit reset per window.
    always_comb begin
        candidate = ((cnt == '0) ? '0 : {1'b0, acc}) + {1'b0, s2};
`ifdef COMP_SUM_SAT_EN
        stored = candidate[OUT_WIDTH] ? '1 : candidate[OUT_WIDTH-1:0];
`else
        stored = candidate[OUT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1        <= '0;
            s2        <= '0;
            acc       <= '0;
            cnt       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            // Y/Z land one cycle ahead of X; p1 holds their weighted part until X shows up.
            p1 <= (OUT_WIDTH'(Z) << 2) + (OUT_WIDTH'(Y) << 1);
            v1 <= yz_valid;
            v2 <= v1;
            if (v1) begin
                s2 <= p1 + OUT_WIDTH'(X);
            end

            if (clear) begin
                v1       <= 1'b0;
                v2       <= 1'b0;
                cnt      <= '0;
                acc      <= '0;
                overflow <= 1'b0;
            end else if (v2) begin
                if (candidate[OUT_WIDTH]) begin
                    overflow <= 1'b1;
                end
                if (cnt == LAST_IDX) begin
                    sum_out   <= stored;
                    sum_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    acc <= stored;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_compressor_sum_accumulator.sv
// Drives four differently configured accumulators with one X/Y/Z stream and checks them against a window-sum model.
module tb_compressor_sum_accumulator;

    localparam int NI = 4;
    localparam int ALEN[NI] = '{1, 3, 2, 2};
    localparam int OWP[NI]  = '{12, 11, 12, 11};
    localparam int HN = 4096;
`ifdef COMP_SUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bit         clk;
    logic       rst_n;
    logic       yz_valid;
    logic [7:0] X, Y, Z;
    logic       clear;

    logic [11:0] so0, so2;
    logic [10:0] so1, so3;
    logic        sv0, sv1, sv2, sv3;
    logic        ov0, ov1, ov2, ov3;

    logic [11:0] got_out[NI];
    logic        got_vld[NI];
    logic        got_ovf[NI];

    compressor_sum_accumulator #(.WIDTH(8), .OUT_WIDTH(12), .ACC_LEN(1)) u0 (
        .clk(clk), .rst_n(rst_n), .yz_valid(yz_valid), .X(X), .Y(Y), .Z(Z), .clear(clear),
        .sum_out(so0), .sum_valid(sv0), .overflow(ov0));
    compressor_sum_accumulator #(.WIDTH(8), .OUT_WIDTH(11), .ACC_LEN(3)) u1 (
        .clk(clk), .rst_n(rst_n), .yz_valid(yz_valid), .X(X), .Y(Y), .Z(Z), .clear(clear),
        .sum_out(so1), .sum_valid(sv1), .overflow(ov1));
    compressor_sum_accumulator #(.WIDTH(8), .OUT_WIDTH(12), .ACC_LEN(2)) u2 (
        .clk(clk), .rst_n(rst_n), .yz_valid(yz_valid), .X(X), .Y(Y), .Z(Z), .clear(clear),
        .sum_out(so2), .sum_valid(sv2), .overflow(ov2));
    compressor_sum_accumulator #(.WIDTH(8), .OUT_WIDTH(11), .ACC_LEN(2)) u3 (
        .clk(clk), .rst_n(rst_n), .yz_valid(yz_valid), .X(X), .Y(Y), .Z(Z), .clear(clear),
        .sum_out(so3), .sum_valid(sv3), .overflow(ov3));

    assign got_out[0] = so0;
    assign got_out[1] = {1'b0, so1};
    assign got_out[2] = so2;
    assign got_out[3] = {1'b0, so3};
    assign got_vld[0] = sv0;
    assign got_vld[1] = sv1;
    assign got_vld[2] = sv2;
    assign got_vld[3] = sv3;
    assign got_ovf[0] = ov0;
    assign got_ovf[1] = ov1;
    assign got_ovf[2] = ov2;
    assign got_ovf[3] = ov3;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Input history per cycle index; a sample is its Y/Z at cycle n plus X at cycle n+1.
    bit         h_yz[HN];
    bit         h_clr[HN];
    bit         h_rst[HN];
    logic [7:0] h_x[HN], h_y[HN], h_z[HN];

    longint m_acc[NI], m_out[NI];
    int     m_cnt[NI];
    bit     m_vld[NI], m_ovf[NI];

    int     pulses[NI];
    longint last_pulse[NI];
    int     pulse_cyc[NI];

    task automatic check(input string nm, input int i, input logic [63:0] got, input longint exp);
        n_chk++;
        if (got !== 64'(exp)) begin
            n_err++;
            $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", nm, i, cyc, got, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = 0; m_out[i] = 0; m_cnt[i] = 0; m_vld[i] = 0; m_ovf[i] = 0;
        end
    endtask

    always @(negedge rst_n) begin
        if (cyc < HN) h_rst[cyc] = 1'b1;
        model_zero();
    end

    // Reference model: a sample survives if no clear or reset touches it in its three pipeline cycles.
    always @(posedge clk) begin
        int     t;
        longint val, mx, s;
        t = cyc;
        if (t < HN) begin
            h_yz[t] = yz_valid; h_x[t] = X; h_y[t] = Y; h_z[t] = Z; h_clr[t] = clear;
        end
        for (int i = 0; i < NI; i++) m_vld[i] = 1'b0;
        if (!rst_n) begin
            if (t < HN) h_rst[t] = 1'b1;
            model_zero();
        end else if (clear) begin
            for (int i = 0; i < NI; i++) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            end
        end else if (t >= 2 && t < HN && h_yz[t-2] && !h_clr[t-2] && !h_clr[t-1]
                     && !h_rst[t-2] && !h_rst[t-1] && !h_rst[t]) begin
            val = longint'(h_x[t-1]) + 2 * longint'(h_y[t-2]) + 4 * longint'(h_z[t-2]);
            for (int i = 0; i < NI; i++) begin
                mx = (64'd1 << OWP[i]) - 1;
                s  = m_acc[i] + val;
                if (s > mx) begin
                    m_ovf[i] = 1'b1;
                    s = SAT ? mx : s - (mx + 1);
                end
                m_cnt[i]++;
                if (m_cnt[i] == ALEN[i]) begin
                    m_out[i] = s; m_vld[i] = 1'b1; m_cnt[i] = 0; m_acc[i] = 0;
                end else begin
                    m_acc[i] = s;
                end
            end
        end
        cyc = t + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            check("sum_valid", i, 64'(got_vld[i]), longint'(m_vld[i]));
            check("sum_out",   i, 64'(got_out[i]), m_out[i]);
            check("overflow",  i, 64'(got_ovf[i]), longint'(m_ovf[i]));
            if (got_vld[i] === 1'b1) begin
                pulses[i]++;
                last_pulse[i] = longint'(got_out[i]);
                pulse_cyc[i]  = cyc;
            end
        end
    end

    bit         pend_v;
    logic [7:0] pend_x;

    task automatic tick(input bit v, input logic [7:0] y, input logic [7:0] z,
                        input logic [7:0] xn, input bit c);
        yz_valid = v; Y = y; Z = z; clear = c;
        X = pend_v ? pend_x : 8'hFF;
        pend_v = v; pend_x = xn;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    endtask

    task automatic flush();
        tick(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(3);
    endtask

    initial begin
        int s, p;
        rst_n = 1'b0; yz_valid = 1'b0; X = '0; Y = '0; Z = '0; clear = 1'b0;
        pend_v = 1'b0; pend_x = '0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_sum_out", i, 64'(got_out[i]), 0);
            check("reset_valid",   i, 64'(got_vld[i]), 0);
            check("reset_ovf",     i, 64'(got_ovf[i]), 0);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single sample, ACC_LEN=1: 3 + 2 + 4 = 9, pulse three cycles after Y/Z.
        flush();
        s = cyc; p = pulses[0];
        tick(1'b1, 8'd1, 8'd1, 8'd3, 1'b0);
        idle(5);
        check("basic_pulses", 0, 64'(pulses[0]), p + 1);
        check("basic_value",  0, 64'(last_pulse[0]), 9);
        check("basic_cycle",  0, 64'(pulse_cyc[0]), s + 3);

        // Back-to-back window of three 9s.
        flush();
        s = cyc; p = pulses[1];
        repeat (3) tick(1'b1, 8'd1, 8'd1, 8'd3, 1'b0);
        idle(5);
        check("window_pulses", 1, 64'(pulses[1]), p + 1);
        check("window_value",  1, 64'(last_pulse[1]), 27);
        check("window_cycle",  1, 64'(pulse_cyc[1]), s + 5);

        // Gapped window; X on gap cycles is 0xFF.
        flush();
        p = pulses[1];
        repeat (3) begin
            tick(1'b1, 8'd1, 8'd1, 8'd3, 1'b0);
            idle(2);
        end
        idle(4);
        check("gap_pulses", 1, 64'(pulses[1]), p + 1);
        check("gap_value",  1, 64'(last_pulse[1]), 27);

        // Two all-ones samples: 3570 fits in 12 bits, wraps or saturates in 11 bits.
        flush();
        repeat (2) tick(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        idle(5);
        check("ovf12_value", 2, 64'(last_pulse[2]), 3570);
        check("ovf12_flag",  2, 64'(got_ovf[2]), 0);
        check("ovf11_value", 3, 64'(last_pulse[3]), SAT ? 2047 : 1522);
        check("ovf11_flag",  3, 64'(got_ovf[3]), 1);

        // Clear coincident with the third sample's final stage discards the window.
        flush();
        p = pulses[1];
        repeat (3) tick(1'b1, 8'd1, 8'd1, 8'd3, 1'b0);
        tick(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        tick(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        idle(3);
        check("clear_pulses", 1, 64'(pulses[1]), p);
        check("clear_ovf",    1, 64'(got_ovf[1]), 0);
        repeat (3) tick(1'b1, 8'd1, 8'd1, 8'd3, 1'b0);
        idle(5);
        check("clear_next_pulses", 1, 64'(pulses[1]), p + 1);
        check("clear_next_value",  1, 64'(last_pulse[1]), 27);

        // Asynchronous reset in the middle of a window.
        flush();
        repeat (2) tick(1'b1, 8'd1, 8'd1, 8'd3, 1'b0);
        yz_valid = 1'b0; X = pend_x; pend_v = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_sum_out", 1, 64'(got_out[1]), 0);
        check("rst_valid",   1, 64'(got_vld[1]), 0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        p = pulses[1];
        idle(2);
        repeat (3) tick(1'b1, 8'd1, 8'd1, 8'd3, 1'b0);
        idle(5);
        check("rst_next_pulses", 1, 64'(pulses[1]), p + 1);
        check("rst_next_value",  1, 64'(last_pulse[1]), 27);

        // Random traffic with occasional clears.
        for (int k = 0; k < 1500; k++) begin
            tick($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 49) == 0);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
